// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter: two per-requester FIFOs (ALU, LSU) drained into
// the register file's single write port. Optional macro WB_X0_FILTER_EN suppresses x0 writes/hazards.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AluValid,
    output logic              AluReady,
    input  logic [ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0] AluData,
    input  logic              LsuValid,
    output logic              LsuReady,
    input  logic [ADDR_W-1:0] LsuAddr,
    input  logic [DATA_W-1:0] LsuData,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] WriteData,
    output logic              ReadWriteEn,
    input  logic [ADDR_W-1:0] ReadAddress1,
    input  logic [ADDR_W-1:0] ReadAddress2,
    output logic              Hazard1,
    output logic              Hazard2,
    output logic              Idle
);

`ifdef WB_X0_FILTER_EN
    localparam logic X0_FILTER = 1'b1;
`else
    localparam logic X0_FILTER = 1'b0;
`endif
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {REQ_ALU = 1'b0, REQ_LSU = 1'b1} req_e;

    logic [ADDR_W-1:0] addrMem  [2][DEPTH];
    logic [DATA_W-1:0] dataMem  [2][DEPTH];
    logic [DEPTH-1:0]  occupied [2];
    logic [PTR_W-1:0]  wrPtr    [2];
    logic [PTR_W-1:0]  rdPtr    [2];
    logic [CNT_W-1:0]  count    [2];
    logic [ADDR_W-1:0] inAddr   [2];
    logic [DATA_W-1:0] inData   [2];
    logic [1:0]        inValid, full, nonEmpty, push, grant;
    logic              sel;
    req_e              lastGrant, grantReq;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    logic              writeSuppressed;

    assign inValid   = {LsuValid, AluValid};
    assign inAddr[0] = AluAddr;
    assign inAddr[1] = LsuAddr;
    assign inData[0] = AluData;
    assign inData[1] = LsuData;

    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            full[r]     = (count[r] == FULL_CNT);
            nonEmpty[r] = (count[r] != '0);
            push[r]     = inValid[r] & ~full[r];
        end
    end

    assign AluReady = ~full[0];
    assign LsuReady = ~full[1];

    // A requester wins outright when alone, otherwise the one not granted last time.
    always_comb begin
        grant[0]        = nonEmpty[0] & (~nonEmpty[1] | (lastGrant == REQ_LSU));
        grant[1]        = nonEmpty[1] & (~nonEmpty[0] | (lastGrant == REQ_ALU));
        sel             = grant[1];
        grantReq        = grant[1] ? REQ_LSU : REQ_ALU;
        headAddr        = addrMem[sel][rdPtr[sel]];
        headData        = dataMem[sel][rdPtr[sel]];
        writeSuppressed = X0_FILTER && (headAddr == '0);
    end

    always_ff @(posedge CLK) begin
        for (int unsigned r = 0; r < 2; r++) begin
            if (push[r]) begin
                addrMem[r][wrPtr[r]] <= inAddr[r];
                dataMem[r][wrPtr[r]] <= inData[r];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned r = 0; r < 2; r++) begin
                wrPtr[r]    <= '0;
                rdPtr[r]    <= '0;
                count[r]    <= '0;
                occupied[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < 2; r++) begin
                if (push[r])
                    wrPtr[r] <= wrPtr[r] + PTR_W'(1);
                if (grant[r])
                    rdPtr[r] <= rdPtr[r] + PTR_W'(1);
                occupied[r] <= (occupied[r] | (push[r] ? (DEPTH'(1) << wrPtr[r]) : '0))
                             & ~(grant[r] ? (DEPTH'(1) << rdPtr[r]) : '0);
                count[r]    <= count[r] + CNT_W'(push[r]) - CNT_W'(grant[r]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ReadWriteEn  <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
            lastGrant    <= REQ_LSU;
        end else begin
            ReadWriteEn <= 1'b0;
            if (|grant) begin
                lastGrant <= grantReq;
                if (!writeSuppressed) begin
                    ReadWriteEn  <= 1'b1;
                    WriteAddress <= headAddr;
                    WriteData    <= headData;
                end
            end
        end
    end

    // Only occupied FIFO slots count; stale slot contents must never raise a hazard.
    always_comb begin
        Hazard1 = ReadWriteEn && (WriteAddress == ReadAddress1);
        Hazard2 = ReadWriteEn && (WriteAddress == ReadAddress2);
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (occupied[r][i] && (addrMem[r][i] == ReadAddress1))
                    Hazard1 = 1'b1;
                if (occupied[r][i] && (addrMem[r][i] == ReadAddress2))
                    Hazard2 = 1'b1;
            end
        end
        if (X0_FILTER && (ReadAddress1 == '0))
            Hazard1 = 1'b0;
        if (X0_FILTER && (ReadAddress2 == '0))
            Hazard2 = 1'b0;
    end

    assign Idle = ~nonEmpty[0] & ~nonEmpty[1] & ~ReadWriteEn;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and sequencer for the 32x32 register file's single write port.
- Two producers share the port: ALU results (requester 0) and load/LSU results (requester 1).
- Each producer has its own small FIFO. A round-robin grant drains one entry per cycle into registered write-port signals (WriteAddress, WriteData, ReadWriteEn).
- Also flags read-after-write hazards on the two read addresses so decode can stall.

Parameters:
- DEPTH, 2, entries per requester FIFO; power of two, at least 2.
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- AluValid  in  1  ALU write request valid.
- AluReady  out  1  ALU FIFO can accept an entry.
- AluAddr  in  ADDR_W  ALU destination register.
- AluData  in  DATA_W  ALU result.
- LsuValid  in  1  LSU write request valid.
- LsuReady  out  1  LSU FIFO can accept an entry.
- LsuAddr  in  ADDR_W  LSU destination register.
- LsuData  in  DATA_W  load result.
- WriteAddress  out  ADDR_W  register-file write address (registered).
- WriteData  out  DATA_W  register-file write data (registered).
- ReadWriteEn  out  1  register-file write enable (registered).
- ReadAddress1  in  ADDR_W  read port 1 address, used for the hazard check.
- ReadAddress2  in  ADDR_W  read port 2 address, used for the hazard check.
- Hazard1  out  1  a write to ReadAddress1 is still pending.
- Hazard2  out  1  a write to ReadAddress2 is still pending.
- Idle  out  1  both FIFOs empty and ReadWriteEn low.

Behaviour:
- Reset (RST high at posedge):
  - Both FIFOs emptied; pointers and counts set to 0.
  - ReadWriteEn=0, WriteAddress=0, WriteData=0.
  - Round-robin LastGrant=1, so requester 0 wins the first tie.
  - Reset mid-operation silently discards buffered writes. Valid inputs during the RST cycle are not accepted.
- Push:
  - AluReady = ~aluFull, LsuReady = ~lsuFull.
  - Entry stored on posedge when Valid & Ready & ~RST.
  - No push while full, even if a pop happens in the same cycle. Ready depends on count only and is never combinational on the grant.
- Grant (combinational, from FIFO state at the start of the cycle):
  - Only one FIFO non-empty: it is granted.
  - Both non-empty: grant the requester != LastGrant.
  - LastGrant updates to the granted index on each grant.
  - Neither non-empty: no grant; LastGrant holds.
- Pop and output stage (posedge):
  - Granted head is popped and loaded into WriteAddress/WriteData, with ReadWriteEn=1.
  - With no grant, ReadWriteEn=0 and WriteAddress/WriteData hold their previous values.
- Latency:
  - Entry pushed at edge N is grantable in cycle N→N+1.
  - It drives ReadWriteEn during N+1→N+2 and is written into the register file at edge N+2.
  - Minimum 2 cycles from acceptance to architectural write.
- Throughput: one write per cycle sustained. A requester pushing every cycle with the other idle never stalls.
- Ordering: per-requester FIFO order is preserved. No cross-requester ordering is guaranteed beyond round-robin.
- FIFO indices wrap modulo DEPTH. Count runs 0..DEPTH; full means count==DEPTH.
- Hazard1/2 (combinational) assert when ReadAddress matches any of:
  - a valid entry in either FIFO;
  - WriteAddress while ReadWriteEn=1.
- Idle is combinational.

Optional Feature:
- Macro: WB_X0_FILTER_EN.
- Defined:
  - Entries with address 0 are still accepted, arbitrated and popped (they consume the grant slot).
  - They produce ReadWriteEn=0, so x0 is never written.
  - They never raise Hazard1/2 (a read of x0 never hazards).
- Undefined: address 0 is treated like any other register (written, hazard-checked).

Test Plan:
- Single ALU write:
  - Stimulus: after reset, AluValid=1, AluAddr=5, AluData=0xDEADBEEF for one cycle (edge N).
  - Response: ReadWriteEn=1, WriteAddress=5, WriteData=0xDEADBEEF exactly in cycle N+1→N+2, then 0. Hazard1 high with ReadAddress1=5 from N until N+2.
- Simultaneous requests:
  - Stimulus: ALU (r1, 0x11) and LSU (r2, 0x22) valid in the same cycle after reset.
  - Response: r1 written first, r2 on the next cycle (LastGrant=1 at reset).
- Back-pressure:
  - Stimulus: stream 4 LSU writes (r3..r6) back-to-back while the ALU holds 3 back-to-back writes.
  - Response: writes alternate ALU/LSU while both are non-empty. LsuReady drops only if the LSU count reaches 2. All 7 writes appear exactly once, each requester in FIFO order.
- Reset mid-operation:
  - Stimulus: fill both FIFOs (2 entries each), assert RST one cycle.
  - Response: ReadWriteEn=0 the next cycle. No buffered write ever appears. Idle=1, AluReady=LsuReady=1.
- x0 handling:
  - Stimulus: ALU write to addr 0 with data 0x55.
  - Response with WB_X0_FILTER_EN defined: ReadWriteEn stays 0 and Hazard1 stays 0 with ReadAddress1=0.
  - Response without the macro: ReadWriteEn=1, WriteAddress=0.
- Wrap-around:
  - Stimulus: 10 consecutive ALU writes r1..r10 with data equal to the index, LSU idle.
  - Response: 10 consecutive ReadWriteEn cycles with correct address/data order. AluReady never deasserts.
